main_ctrl: RTL and testbench
============================

// Module: main_ctrl
// PURPOSE
// - Top-level user-command decoder for the Game-of-Life core. Takes PS/2 set-2 scan bytes from
//   the keyboard receiver and turns key presses into one-cycle command pulses.
// - win_ctrl_cmd drives the viewport/cursor controller. envo_ctrl_cmd drives the evolution engine.
// - Also owns two registers: view_width (zoom level) and mode (0 = edit/paused, 1 = run).
// PARAMETERS
// VW_DEFAULT  32   view_width after reset
// VW_MIN      8    smallest view_width (saturating)
// VW_MAX      128  largest view_width (saturating)
// VW_STEP     8    view_width change per zoom key
// PORTS
// clk            in   1  system clock; single clock domain, all logic on posedge
// rst            in   1  asynchronous, active-low reset
// ps2_byte       in   8  scan byte from PS/2 receiver; valid while ps2_state=1
// ps2_state      in   1  byte-valid level; may stay high for any number of cycles
// win_ctrl_cmd   out  7  one-hot pulse: [0]up [1]down [2]left [3]right [4]zoom-in [5]zoom-out [6]toggle-cell
// envo_ctrl_cmd  out  7  one-hot pulse: [0]run [1]pause [2]step [3]clear [4]random-seed [5]faster [6]slower
// view_width     out  8  current viewport width in cells
// mode           out  1  0 = edit (paused), 1 = run
// BEHAVIOUR
// - Reset (rst=0, async):
//   - win_ctrl_cmd=0, envo_ctrl_cmd=0, view_width=VW_DEFAULT, mode=0.
//   - Break and extended flags clear; previous-state register clears.
// - Byte acceptance:
//   - A register holds the previous ps2_state.
//   - A byte is accepted at the posedge where ps2_state=1 and prev=0; one byte per rising edge.
//   - A held-high ps2_state never repeats a byte.
// - Latency: command pulses are registered. Accept at edge N -> cmd bit high for exactly one clock
//   after edge N, then 0. All command bits are 0 when there is no accepted byte.
// - Prefix handling:
//   - 0xF0 sets the break flag. The next accepted byte is discarded, and both flags clear.
//     Key releases therefore produce no command.
//   - 0xE0 sets the extended flag; it applies to the next accepted byte only.
//   - Prefix bytes themselves emit nothing.
// - Decode of make codes (any mode unless noted):
//   - 1D(W) / E0 75 -> win[0].  1B(S) / E0 72 -> win[1].  1C(A) / E0 6B -> win[2].
//     23(D) / E0 74 -> win[3].
//   - 24(E) -> win[4]. view_width -= VW_STEP, saturating at VW_MIN.
//   - 15(Q) -> win[5]. view_width += VW_STEP, saturating at VW_MAX.
//     The pulse is emitted even when saturated; view_width updates on the same edge as the pulse.
//   - 5A(Enter) -> win[6], edit mode only.
//   - 29(Space) toggles mode. 0->1 emits envo[0]; 1->0 emits envo[1].
//   - 31(N) -> envo[2], edit mode only.
//   - 21(C) -> envo[3]. Also forces mode=0, with no separate pause pulse.
//   - 2D(R) -> envo[4], edit mode only.
//   - 79(KP+) -> envo[5].  7B(KP-) -> envo[6].
//   - Any other byte, or any gated key in the wrong mode: no pulse, no state change.
// - At most one bit of win_ctrl_cmd or envo_ctrl_cmd is high in any cycle.
// - Reset asserted mid-pulse clears the outputs immediately.
// TESTING
// - Hold rst=1, then rst=0 -> outputs 0 and view_width=32 immediately, without waiting for a clock.
//   Release rst=1.
// - ps2_byte=0x23, ps2_state high for 3 clocks -> win_ctrl_cmd=7'b0001000 for exactly 1 clock,
//   then 0; no repeat.
// - Sequence F0,23 -> no pulse. Then E0,75 -> win_ctrl_cmd=7'b0000001 once.
// - Space -> mode=1 and envo_ctrl_cmd=7'b0000001. Then N -> no pulse. Then Space -> mode=0 and
//   envo_ctrl_cmd=7'b0000010.
// - Q x20 -> view_width=40,48,...,128 then stays 128. Then E x20 -> view_width ends at 8.
// - In run mode, C -> envo_ctrl_cmd=7'b0001000 and mode=0. Enter in run mode -> no win[6].

Source files
------------

// File: rtl/main_ctrl.sv
// Game-of-Life command decoder: turns PS/2 set-2 make codes into one-cycle command pulses
// for the viewport and evolution engines, and holds the zoom width and run/edit mode.
module main_ctrl #(
  parameter logic [7:0] VW_DEFAULT = 8'd32,
  parameter logic [7:0] VW_MIN     = 8'd8,
  parameter logic [7:0] VW_MAX     = 8'd128,
  parameter logic [7:0] VW_STEP    = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_state,
  output logic [6:0] win_ctrl_cmd,
  output logic [6:0] envo_ctrl_cmd,
  output logic [7:0] view_width,
  output logic       mode
);

  // state     | meaning
  // MODE_EDIT | paused; cell edit, single step and random seed allowed
  // MODE_RUN  | evolution running; edit-only keys ignored
  typedef enum logic {MODE_EDIT = 1'b0, MODE_RUN = 1'b1} mode_e;

  mode_e      mode_q, mode_d;
  logic       prev_q, prev_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [6:0] win_q, win_d;
  logic [6:0] envo_q, envo_d;
  logic [7:0] vw_q, vw_d;
  logic       accept;
  logic       edit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_EDIT;
      prev_q <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      win_q  <= '0;
      envo_q <= '0;
      vw_q   <= VW_DEFAULT;
    end else begin
      mode_q <= mode_d;
      prev_q <= prev_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      win_q  <= win_d;
      envo_q <= envo_d;
      vw_q   <= vw_d;
    end
  end

  always_comb begin
    accept = ps2_state & ~prev_q;
    edit   = (mode_q == MODE_EDIT);
    prev_d = ps2_state;
    brk_d  = brk_q;
    ext_d  = ext_q;
    win_d  = '0;
    envo_d = '0;
    vw_d   = vw_q;
    mode_d = mode_q;
    if (accept) begin
      if (brk_q) begin
        // byte following F0 is the released key: swallow it
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (ps2_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else if (ps2_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        case (ps2_byte)
          8'h75:   win_d[0] = 1'b1;
          8'h72:   win_d[1] = 1'b1;
          8'h6B:   win_d[2] = 1'b1;
          8'h74:   win_d[3] = 1'b1;
          default: ;
        endcase
      end else begin
        case (ps2_byte)
          8'h1D: win_d[0] = 1'b1;
          8'h1B: win_d[1] = 1'b1;
          8'h1C: win_d[2] = 1'b1;
          8'h23: win_d[3] = 1'b1;
          8'h24: begin
            win_d[4] = 1'b1;
            vw_d = (vw_q <= VW_MIN + VW_STEP) ? VW_MIN : vw_q - VW_STEP;
          end
          8'h15: begin
            win_d[5] = 1'b1;
            vw_d = (vw_q >= VW_MAX - VW_STEP) ? VW_MAX : vw_q + VW_STEP;
          end
          8'h5A: win_d[6] = edit;
          8'h29: begin
            if (edit) begin
              mode_d    = MODE_RUN;
              envo_d[0] = 1'b1;
            end else begin
              mode_d    = MODE_EDIT;
              envo_d[1] = 1'b1;
            end
          end
          8'h31: envo_d[2] = edit;
          8'h21: begin
            envo_d[3] = 1'b1;
            mode_d    = MODE_EDIT;
          end
          8'h2D: envo_d[4] = edit;
          8'h79: envo_d[5] = 1'b1;
          8'h7B: envo_d[6] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign win_ctrl_cmd  = win_q;
  assign envo_ctrl_cmd = envo_q;
  assign view_width    = vw_q;
  assign mode          = mode_q;

endmodule

// File: tb/tb_main_ctrl.sv
// Directed bench for main_ctrl: one task per scenario, expected values written by hand.
module tb_main_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic [6:0] win_ctrl_cmd;
  logic [6:0] envo_ctrl_cmd;
  logic [7:0] view_width;
  logic       mode;

  int n_checks = 0;
  int n_fail   = 0;

  main_ctrl dut (
    .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_state(ps2_state),
    .win_ctrl_cmd(win_ctrl_cmd), .envo_ctrl_cmd(envo_ctrl_cmd),
    .view_width(view_width), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents byte b with ps2_state high for 'hold' clocks. w/e are the outputs just after
  // the accepting edge; extra is set if any command bit shows up on later edges.
  task automatic send(input logic [7:0] b, input int hold,
                      output logic [6:0] w, output logic [6:0] e, output logic extra);
    @(negedge clk);
    ps2_byte  = b;
    ps2_state = 1'b1;
    @(posedge clk); #1;
    w = win_ctrl_cmd;
    e = envo_ctrl_cmd;
    extra = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      extra = extra | (|win_ctrl_cmd) | (|envo_ctrl_cmd);
    end
    @(negedge clk);
    ps2_state = 1'b0;
    @(posedge clk); #1;
    extra = extra | (|win_ctrl_cmd) | (|envo_ctrl_cmd);
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (win_ctrl_cmd !== 7'd0 || envo_ctrl_cmd !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_cmd: win=%b envo=%b required 0/0", win_ctrl_cmd, envo_ctrl_cmd);
    end
    n_checks++;
    if (view_width !== 8'd32 || mode !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: vw=%0d mode=%b required 32/0", view_width, mode);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_hold();
    logic [6:0] w, e;
    logic x;
    send(8'h23, 3, w, e, x);
    n_checks++;
    if (w !== 7'b0001000 || e !== 7'd0 || x !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_right: win=%b envo=%b repeat=%b required 0001000/0000000/0", w, e, x);
    end
  endtask

  task automatic test_prefix();
    logic [6:0] w, e;
    logic x;
    logic [7:0] seq  [8] = '{8'hF0, 8'h23, 8'hE0, 8'h75, 8'h75, 8'hE0, 8'hF0, 8'h72};
    logic [6:0] expw [8] = '{7'd0, 7'd0, 7'd0, 7'b0000001, 7'd0, 7'd0, 7'd0, 7'd0};
    logic [7:0] key  [8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h72, 8'h6B, 8'h74, 8'h75};
    logic [6:0] keyw [8] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                             7'b0000010, 7'b0000100, 7'b0001000, 7'b0000001};
    for (int i = 0; i < 8; i++) begin
      send(seq[i], 1, w, e, x);
      n_checks++;
      if (w !== expw[i] || e !== 7'd0 || x !== 1'b0) begin
        n_fail++;
        $display("FAIL prefix_seq[%0d]: win=%b envo=%b repeat=%b required %b/0000000/0",
                 i, w, e, x, expw[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) send(8'hE0, 1, w, e, x);
      send(key[i], 1, w, e, x);
      n_checks++;
      if (w !== keyw[i] || e !== 7'd0) begin
        n_fail++;
        $display("FAIL nav_key[%0d]: win=%b envo=%b required %b/0000000", i, w, e, keyw[i]);
      end
    end
  endtask

  task automatic test_mode();
    logic [6:0] w, e;
    logic x;
    logic [7:0] seq  [10] = '{8'h29, 8'h31, 8'h5A, 8'h2D, 8'h29, 8'h31, 8'h2D, 8'h5A, 8'h79, 8'h7B};
    logic [6:0] expw [10] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b1000000, 7'd0, 7'd0};
    logic [6:0] expe [10] = '{7'b0000001, 7'd0, 7'd0, 7'd0, 7'b0000010,
                              7'b0000100, 7'b0010000, 7'd0, 7'b0100000, 7'b1000000};
    logic       expm [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send(seq[i], 2, w, e, x);
      n_checks++;
      if (w !== expw[i] || e !== expe[i] || mode !== expm[i] || x !== 1'b0) begin
        n_fail++;
        $display("FAIL mode_seq[%0d]: win=%b envo=%b mode=%b repeat=%b required %b/%b/%b/0",
                 i, w, e, mode, x, expw[i], expe[i], expm[i]);
      end
    end
  endtask

  task automatic test_clear();
    logic [6:0] w, e;
    logic x;
    send(8'h29, 1, w, e, x);
    send(8'h21, 1, w, e, x);
    n_checks++;
    if (e !== 7'b0001000 || w !== 7'd0 || mode !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_run: envo=%b win=%b mode=%b required 0001000/0000000/0", e, w, mode);
    end
    send(8'h29, 1, w, e, x);
    send(8'h5A, 1, w, e, x);
    n_checks++;
    if (w !== 7'd0 || e !== 7'd0 || mode !== 1'b1) begin
      n_fail++;
      $display("FAIL enter_run: win=%b envo=%b mode=%b required 0000000/0000000/1", w, e, mode);
    end
    send(8'h21, 1, w, e, x);
    n_checks++;
    if (e !== 7'b0001000 || mode !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_run2: envo=%b mode=%b required 0001000/0", e, mode);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ps2_byte  = 8'h15;
    ps2_state = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (win_ctrl_cmd !== 7'b0100000 || view_width !== 8'd40) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: win=%b vw=%0d required 0100000/40", win_ctrl_cmd, view_width);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (win_ctrl_cmd !== 7'd0 || view_width !== 8'd32) begin
      n_fail++;
      $display("FAIL mid_reset: win=%b vw=%0d required 0000000/32", win_ctrl_cmd, view_width);
    end
    @(negedge clk);
    ps2_state = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_zoom();
    logic [6:0] w, e;
    logic x;
    int exp_vw = 32;
    for (int i = 0; i < 20; i++) begin
      send(8'h15, 1, w, e, x);
      exp_vw = (exp_vw + 8 > 128) ? 128 : exp_vw + 8;
      n_checks++;
      if (w !== 7'b0100000 || view_width !== exp_vw[7:0]) begin
        n_fail++;
        $display("FAIL zoom_out[%0d]: win=%b vw=%0d required 0100000/%0d", i, w, view_width, exp_vw);
      end
    end
    for (int i = 0; i < 20; i++) begin
      send(8'h24, 1, w, e, x);
      exp_vw = (exp_vw - 8 < 8) ? 8 : exp_vw - 8;
      n_checks++;
      if (w !== 7'b0010000 || view_width !== exp_vw[7:0]) begin
        n_fail++;
        $display("FAIL zoom_in[%0d]: win=%b vw=%0d required 0010000/%0d", i, w, view_width, exp_vw);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    ps2_byte  = 8'h00;
    ps2_state = 1'b0;
    test_reset();
    test_hold();
    test_prefix();
    test_mode();
    test_clear();
    test_reset_mid();
    test_zoom();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
